gen2_frame_rx: RTL and testbench

//  Downstream of the FM0 RX path (preamble correlator + symbol decoder).

---
 rtl/gen2_frame_rx.sv | 174 +++++++++++++++++
 tb/tb_gen2_frame_rx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen2_frame_rx.sv
// Gen2 tag-reply frame collector: gathers decoded FM0 bits into one frame of
// known length, checks the CRC-16 residue and offers the frame over valid/ready.
module gen2_frame_rx #(
  parameter int MAX_BITS = 128,
  parameter int TIMEOUT  = 512,
  localparam int LEN_W   = $clog2(MAX_BITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    exp_len,
  input  logic                crc_en,
  input  logic                in_bit,
  input  logic                in_vld,
  output logic [MAX_BITS-1:0] out_dat,
  output logic [LEN_W-1:0]    out_len,
  output logic                crc_ok,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic                err
);

  localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_BITS);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [15:0]       CRC_INIT  = 16'hFFFF;
  localparam logic [15:0]       CRC_POLY  = 16'h1021;
  localparam logic [15:0]       CRC_RESID = 16'h1D0F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [LEN_W-1:0]    r_len;
  logic                r_crc_en;
  logic [LEN_W-1:0]    r_cnt;
  logic [15:0]         r_crc;
  logic [MAX_BITS-1:0] r_shreg;
  logic [IDLE_W-1:0]   r_idle_cnt;

  logic [MAX_BITS-1:0] r_out_dat;
  logic [LEN_W-1:0]    r_out_len;
  logic                r_crc_ok;
  logic                r_out_vld;
  logic                r_err;

  logic                w_len_ok;
  logic [LEN_W-1:0]    w_cnt_nxt;
  logic [15:0]         w_crc_nxt;
  logic [MAX_BITS-1:0] w_shreg_nxt;
  logic                w_load;
  logic                w_shift;
  logic                w_tick;
  logic                w_finish;
  logic                w_release;
  logic                w_err;

  assign w_len_ok    = (exp_len != '0) && (exp_len <= MAX_LEN);
  assign w_cnt_nxt   = r_cnt + LEN_W'(1);
  assign w_crc_nxt   = {r_crc[14:0], 1'b0} ^ ((r_crc[15] ^ in_bit) ? CRC_POLY : 16'h0000);
  assign w_shreg_nxt = {r_shreg[MAX_BITS-2:0], in_bit};

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_tick      = 1'b0;
    w_finish    = 1'b0;
    w_release   = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_len_ok) begin
            w_load      = 1'b1;
            w_state_nxt = S_COLLECT;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        // A new preamble wins over the bit and the stall timer in the same cycle.
        if (start) begin
          if (w_len_ok) begin
            w_load = 1'b1;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (in_vld) begin
          w_shift = 1'b1;
          if (w_cnt_nxt == r_len) begin
            w_finish    = 1'b1;
            w_state_nxt = S_DONE;
          end
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tick = 1'b1;
        end
      end
      S_DONE: begin
        // A start while a frame is still held is reported but never disturbs it.
        w_err = start;
        if (r_out_vld && out_rdy) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_crc_en   <= 1'b0;
      r_cnt      <= '0;
      r_crc      <= '0;
      r_shreg    <= '0;
      r_idle_cnt <= '0;
      r_out_dat  <= '0;
      r_out_len  <= '0;
      r_crc_ok   <= 1'b0;
      r_out_vld  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err;
      if (w_load) begin
        r_len      <= exp_len;
        r_crc_en   <= crc_en;
        r_cnt      <= '0;
        r_crc      <= CRC_INIT;
        r_shreg    <= '0;
        r_idle_cnt <= '0;
      end
      if (w_shift) begin
        r_shreg    <= w_shreg_nxt;
        r_cnt      <= w_cnt_nxt;
        r_crc      <= w_crc_nxt;
        r_idle_cnt <= '0;
      end
      if (w_tick) begin
        r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
      end
      // Publish from the next-state values so out_vld follows the last bit by one clock.
      if (w_finish) begin
        r_out_vld <= 1'b1;
        r_out_dat <= w_shreg_nxt;
        r_out_len <= r_len;
        r_crc_ok  <= r_crc_en ? (w_crc_nxt == CRC_RESID) : 1'b1;
      end
      if (w_release) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign out_dat = r_out_dat;
  assign out_len = r_out_len;
  assign crc_ok  = r_crc_ok;
  assign out_vld = r_out_vld;
  assign err     = r_err;

endmodule

// File: tb/tb_gen2_frame_rx.sv
// Bench for gen2_frame_rx: cycle table, directed corner sequences and random
// frames checked against a frame-level reference model.
module tb_gen2_frame_rx;

  localparam int MAX_BITS = 128;
  localparam int TIMEOUT  = 512;
  localparam int LEN_W    = $clog2(MAX_BITS + 1);

  logic                clk = 1'b0;
  logic                rst, start, crc_en, in_bit, in_vld, out_rdy;
  logic [LEN_W-1:0]    exp_len;
  logic [MAX_BITS-1:0] out_dat;
  logic [LEN_W-1:0]    out_len;
  logic                crc_ok, out_vld, err;

  int n_vec  = 0;
  int n_miss = 0;

  gen2_frame_rx #(.MAX_BITS(MAX_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .exp_len(exp_len), .crc_en(crc_en),
    .in_bit(in_bit), .in_vld(in_vld), .out_dat(out_dat), .out_len(out_len),
    .crc_ok(crc_ok), .out_vld(out_vld), .out_rdy(out_rdy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  typedef struct {
    logic rst, start;
    logic [LEN_W-1:0] len;
    logic ce, bi, vld, rdy;
    logic e_vld, e_err, chk_dat;
    logic [15:0] e_dat;
    logic [LEN_W-1:0] e_len;
    logic e_ok;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, s, input int len, input logic ce, bi, vld, rdy,
                     input logic e_vld, e_err, chk_dat, input int e_dat, e_len, input logic e_ok);
    vec_t v;
    v.rst = r; v.start = s; v.len = LEN_W'(len); v.ce = ce; v.bi = bi; v.vld = vld; v.rdy = rdy;
    v.e_vld = e_vld; v.e_err = e_err; v.chk_dat = chk_dat;
    v.e_dat = 16'(e_dat); v.e_len = LEN_W'(e_len); v.e_ok = e_ok;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Reference model: frame value, CRC-16 over a bit list, and the Gen2 rule
  // that the trailing 16 bits are the ones' complement of the CRC of the rest.
  function automatic logic [127:0] pack(input logic q[$]);
    logic [127:0] v = '0;
    foreach (q[i]) v = {v[126:0], q[i]};
    return v;
  endfunction

  function automatic logic [15:0] crc16(input logic q[$], input int n);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < n; i++) c = (c << 1) ^ (((c[15] ^ q[i]) != 1'b0) ? 16'h1021 : 16'h0000);
    return c;
  endfunction

  function automatic logic model_ok(input logic q[$], input logic ce);
    logic [15:0] tail = '0;
    int n = q.size();
    if (!ce) return 1'b1;
    for (int i = n - 16; i < n; i++) tail = {tail[14:0], q[i]};
    return (~crc16(q, n - 16)) == tail;
  endfunction

  task automatic run_frame(input string nm, input logic q[$], input logic ce,
                           input int gap_max, input int hold, input logic exp_ok);
    logic bad = 1'b0;
    logic [127:0] want = pack(q);
    out_rdy = (hold == 0);
    start = 1'b1; exp_len = LEN_W'(q.size()); crc_en = ce; in_vld = 1'b0;
    step();
    start = 1'b0;
    foreach (q[i]) begin
      for (int g = $urandom_range(gap_max, 0); g > 0; g--) begin
        in_vld = 1'b0;
        step();
        bad |= out_vld | err;
      end
      in_vld = 1'b1; in_bit = q[i];
      step();
      if (i < q.size() - 1) bad |= out_vld | err;
    end
    in_vld = 1'b0;
    chk({nm, "_early"}, bad, 0);
    chk({nm, "_vld"}, out_vld, 1);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_dat"}, out_dat, want);
    chk({nm, "_len"}, out_len, q.size());
    chk({nm, "_crc"}, crc_ok, exp_ok);
    bad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      bad |= (out_vld !== 1'b1) || (out_dat !== want);
    end
    if (hold > 0) chk({nm, "_hold"}, bad, 0);
    out_rdy = 1'b1;
    step();
    chk({nm, "_drop"}, out_vld, 0);
  endtask

  initial begin
    logic q[$];
    logic bad;
    int k, pulses;

    rst = 1'b1; start = 1'b0; exp_len = '0; crc_en = 1'b0;
    in_bit = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;

    //   rst st len ce bi vld rdy | vld err chk dat len ok
    add(1, 0, 0,   0, 0, 0, 1,    0, 0, 1, 0, 0, 0);
    add(0, 1, 0,   0, 0, 0, 1,    0, 1, 0, 0, 0, 0);
    add(0, 0, 0,   0, 0, 0, 1,    0, 0, 0, 0, 0, 0);
    add(0, 1, 129, 0, 0, 0, 1,    0, 1, 0, 0, 0, 0);
    add(0, 1, 3,   0, 1, 1, 0,    0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   0, 1, 1, 0,    0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   0, 0, 1, 0,    0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   0, 1, 1, 0,    1, 0, 1, 5, 3, 1);
    add(0, 0, 0,   0, 1, 1, 0,    1, 0, 1, 5, 3, 1);
    add(0, 1, 5,   0, 0, 0, 0,    1, 1, 1, 5, 3, 1);
    add(0, 0, 0,   0, 0, 0, 1,    0, 0, 0, 0, 0, 0);
    add(0, 1, 2,   0, 0, 0, 1,    0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   0, 1, 1, 1,    0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   0, 0, 1, 1,    1, 0, 1, 2, 2, 1);
    add(0, 0, 0,   0, 0, 0, 1,    0, 0, 0, 0, 0, 0);
    add(0, 1, 4,   0, 0, 0, 1,    0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   0, 1, 1, 1,    0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   0, 1, 1, 1,    0, 0, 0, 0, 0, 0);
    add(1, 0, 0,   0, 1, 1, 1,    0, 0, 1, 0, 0, 0);
    add(0, 0, 0,   0, 1, 1, 1,    0, 0, 1, 0, 0, 0);
    add(0, 1, 1,   0, 0, 0, 1,    0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   0, 1, 1, 1,    1, 0, 1, 1, 1, 1);
    add(0, 0, 0,   0, 0, 0, 1,    0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; start = tbl[i].start; exp_len = tbl[i].len; crc_en = tbl[i].ce;
      in_bit = tbl[i].bi; in_vld = tbl[i].vld; out_rdy = tbl[i].rdy;
      step();
      chk($sformatf("row%0d_vld", i), out_vld, tbl[i].e_vld);
      chk($sformatf("row%0d_err", i), err, tbl[i].e_err);
      if (tbl[i].chk_dat) begin
        chk($sformatf("row%0d_dat", i), out_dat, 128'(tbl[i].e_dat));
        chk($sformatf("row%0d_len", i), out_len, tbl[i].e_len);
        chk($sformatf("row%0d_ok", i), crc_ok, tbl[i].e_ok);
      end
    end
    rst = 1'b0; start = 1'b0; in_vld = 1'b0;

    // Short frame, CRC off, consumer ready in advance
    q = {};
    for (int i = 15; i >= 0; i--) q.push_back(1'((16'hA5C3 >> i) & 1));
    run_frame("short", q, 1'b0, 0, 0, 1'b1);

    // "123456789" followed by its Gen2 CRC field, then the same with a data bit flipped
    q = {};
    for (int c = 8'h31; c <= 8'h39; c++)
      for (int i = 7; i >= 0; i--) q.push_back(1'((c >> i) & 1));
    for (int i = 15; i >= 0; i--) q.push_back(1'((16'hD64E >> i) & 1));
    run_frame("crc_good", q, 1'b1, 2, 0, 1'b1);
    q[10] = ~q[10];
    run_frame("crc_bad", q, 1'b1, 0, 2, 1'b0);

    // Stalled reply
    out_rdy = 1'b1;
    start = 1'b1; exp_len = LEN_W'(16); crc_en = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_vld = 1'b1; in_bit = 1'($urandom_range(1, 0));
      step();
    end
    in_vld = 1'b0;
    k = 0; bad = 1'b0;
    while (k < TIMEOUT + 20 && err !== 1'b1) begin
      step();
      k++;
      bad |= out_vld;
    end
    chk("to_cycles", k, TIMEOUT);
    chk("to_novld", bad, 0);
    step();
    chk("to_pulse", err, 0);
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(1'($urandom_range(1, 0)));
    run_frame("to_next", q, 1'b0, 1, 0, 1'b1);

    // Backpressure with stray bits and a stray start while the frame is held
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(1'($urandom_range(1, 0)));
    out_rdy = 1'b0;
    start = 1'b1; exp_len = LEN_W'(16); crc_en = 1'b0;
    step();
    start = 1'b0;
    foreach (q[i]) begin
      in_vld = 1'b1; in_bit = q[i];
      step();
    end
    chk("bp_vld", out_vld, 1);
    chk("bp_dat", out_dat, pack(q));
    bad = 1'b0; pulses = 0;
    for (int c = 0; c < 10; c++) begin
      in_vld = (c < 4); in_bit = 1'($urandom_range(1, 0));
      start = (c == 5); exp_len = LEN_W'(8);
      step();
      bad |= (out_vld !== 1'b1) || (out_dat !== pack(q)) || (out_len !== LEN_W'(16)) || (crc_ok !== 1'b1);
      if (err === 1'b1) pulses++;
      if (c == 5) chk("bp_err_at_start", err, 1);
    end
    start = 1'b0; in_vld = 1'b0;
    chk("bp_stable", bad, 0);
    chk("bp_pulses", pulses, 1);
    out_rdy = 1'b1;
    step();
    chk("bp_release", out_vld, 0);

    // Longest legal frame
    q = {};
    for (int i = 0; i < MAX_BITS; i++) q.push_back(1'($urandom_range(1, 0)));
    run_frame("maxlen", q, 1'b0, 1, 1, 1'b1);

    // Restart mid-frame: only the second frame may come out
    start = 1'b1; exp_len = LEN_W'(32); crc_en = 1'b0; out_rdy = 1'b1;
    step();
    start = 1'b0; bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_vld = 1'b1; in_bit = 1'b1;
      step();
      bad |= out_vld | err;
    end
    in_vld = 1'b0;
    chk("restart_quiet", bad, 0);
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(1'(i & 1));
    run_frame("restart", q, 1'b0, 0, 0, 1'b1);

    // Reset mid-frame
    start = 1'b1; exp_len = LEN_W'(32);
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_vld = 1'b1; in_bit = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0; in_vld = 1'b0;
    chk("rst_dat", out_dat, 0);
    chk("rst_len", out_len, 0);
    chk("rst_ok", crc_ok, 0);
    chk("rst_vld", out_vld, 0);
    chk("rst_err", err, 0);
    step();
    chk("rst_err_after", err, 0);

    // Random frames against the model
    for (int f = 0; f < 40; f++) begin
      int len;
      logic ce;
      len = $urandom_range(MAX_BITS, 1);
      ce = (len >= 17) && ($urandom_range(1, 0) == 1);
      q = {};
      for (int i = 0; i < len; i++) q.push_back(1'($urandom_range(1, 0)));
      if (ce && $urandom_range(1, 0) == 1) begin
        logic [15:0] fld;
        fld = ~crc16(q, len - 16);
        for (int i = 0; i < 16; i++) q[len - 16 + i] = fld[15 - i];
      end
      run_frame($sformatf("rnd%0d", f), q, ce, 3, $urandom_range(3, 0), model_ok(q, ce));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
